// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM encoding and constants for spi_reg_ctrl.
package spi_reg_pkg;
  typedef enum logic [2:0] {IDLE, CMD, WR_WAIT, WR_BUS, RD_BUS, RD_WAIT} state_t;
  localparam int CMD_RD_BIT = 7;
  localparam logic [7:0] TIMEOUT_FILL = 8'hEE;
  localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: counts cycles while start is held; expire fires on the LIMIT-th cycle.
module bus_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expire
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign expire = start & (cnt_q == W'(LIMIT - 1));
  always_comb cnt_d = (!start || clear || expire) ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI command sequencer driving an 8-bit req/ack register bus.
// Optional bus watchdog and err_timeout output enabled by SPI_REG_CTRL_TIMEOUT_EN.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic              reg_ack,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
`ifdef SPI_REG_CTRL_TIMEOUT_EN
  output logic              err_timeout,
`endif
  output logic              err_overrun
);
  if (ADDR_W < 1 || ADDR_W > 7 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("spi_reg_ctrl: ADDR_W must be 1..7 and TIMEOUT_CYC >= 1");
  end
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0] tx_q, tx_d, wdata_q, wdata_d;
  logic ovr_q, ovr_d, end_pend_q, end_pend_d, start_pend_q, start_pend_d;
  logic restart, tmo, done;
`ifdef SPI_REG_CTRL_TIMEOUT_EN
  logic tmo_err_q, tmo_err_d;
  bus_watchdog #(.LIMIT(TIMEOUT_CYC)) u_wdog (
    .clk(clk), .rst_n(rst_n), .start(reg_req), .clear(reg_ack), .expire(tmo)
  );
  always_comb tmo_err_d = restart ? 1'b0 : (tmo_err_q | (reg_req & tmo & ~reg_ack));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_err_q <= 1'b0;
    else tmo_err_q <= tmo_err_d;
  assign err_timeout = tmo_err_q;
`else
  assign tmo = 1'b0;
`endif
  assign done = reg_ack | tmo;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      tx_q         <= '0;
      wdata_q      <= '0;
      ovr_q        <= 1'b0;
      end_pend_q   <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tx_q         <= tx_d;
      wdata_q      <= wdata_d;
      ovr_q        <= ovr_d;
      end_pend_q   <= end_pend_d;
      start_pend_q <= start_pend_d;
    end
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tx_d         = tx_q;
    wdata_d      = wdata_q;
    ovr_d        = ovr_q;
    end_pend_d   = end_pend_q;
    start_pend_d = start_pend_q;
    restart      = 1'b0;
    case (state_q)
      IDLE: restart = frame_start;
      CMD, WR_WAIT, RD_WAIT: begin
        if (frame_start) restart = 1'b1;
        else if (frame_end) state_d = IDLE;
        else if (rx_valid) begin
          if (state_q == CMD) begin
            addr_d  = rx_byte[ADDR_W-1:0];
            state_d = rx_byte[CMD_RD_BIT] ? RD_BUS : WR_WAIT;
          end else if (state_q == WR_WAIT) begin
            wdata_d = rx_byte;
            state_d = WR_BUS;
          end else state_d = RD_BUS;
        end
      end
      WR_BUS, RD_BUS: begin
        // Frame edges seen mid-transaction are deferred; the most recent one wins.
        ovr_d        = ovr_q | (rx_valid & ~frame_end);
        start_pend_d = frame_start | (start_pend_q & ~frame_end);
        end_pend_d   = ~frame_start & (frame_end | end_pend_q);
        if (done) begin
          addr_d       = addr_q + ADDR_W'(1);
          tx_d         = (state_q == RD_BUS) ? (reg_ack ? reg_rdata : TIMEOUT_FILL) : tx_q;
          restart      = start_pend_d;
          state_d      = end_pend_d ? IDLE : (state_q == WR_BUS ? WR_WAIT : RD_WAIT);
          start_pend_d = 1'b0;
          end_pend_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d      = CMD;
      tx_d         = STATUS_BYTE;
      ovr_d        = 1'b0;
      end_pend_d   = 1'b0;
      start_pend_d = 1'b0;
    end
  end
  always_comb begin
    reg_req = (state_q == WR_BUS) || (state_q == RD_BUS);
    reg_we  = state_q == WR_BUS;
    busy    = state_q != IDLE;
  end
  assign tx_byte     = tx_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign err_overrun = ovr_q;
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command sequencer between the SPI slave byte datapath and an on-chip 8-bit register bus.
- Parses each SSEL-framed message as one command byte, then data bytes: write with auto-increment, or read streaming.
- Issues req/ack register-bus transactions.
- Supplies the next MISO byte to the SPI slave shifter.

Parameters:
- ADDR_W, 7, register address width; command byte bits [ADDR_W-1:0] form the start address (ADDR_W ≤ 7).
- STATUS_BYTE, 8'hA5, byte loaded into tx_byte at frame start and shifted out during the command byte.
- TIMEOUT_CYC, 64, bus watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- frame_start  in  1  one-cycle pulse, SSEL falling edge, synchronised to clk
- frame_end  in  1  one-cycle pulse, SSEL rising edge
- rx_valid  in  1  one-cycle pulse, full byte received
- rx_byte  in  8  received byte, valid with rx_valid
- tx_byte  out  8  next byte to shift out MSB-first; the slave samples it at the byte boundary
- reg_req  out  1  bus request, held until reg_ack
- reg_we  out  1  1 = write, 0 = read; stable while reg_req
- reg_addr  out  ADDR_W  bus address; stable while reg_req
- reg_wdata  out  8  write data; stable while reg_req
- reg_ack  in  1  one-cycle completion pulse
- reg_rdata  in  8  read data, valid with reg_ack
- busy  out  1  high in any state except IDLE
- err_overrun  out  1  sticky; cleared by frame_start

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, tx_byte 8'h00, reg_req/reg_we 0, reg_addr 0, reg_wdata 0, busy 0, err_overrun 0. Reset mid-transaction drops reg_req immediately.
- State IDLE: frame_start → CMD. Same edge: tx_byte <= STATUS_BYTE, err_overrun <= 0.
- State CMD: rx_valid → latch rw = rx_byte[7], addr = rx_byte[ADDR_W-1:0].
  - rw = 1 → RD_BUS.
  - rw = 0 → WR_WAIT.
- State WR_WAIT: rx_valid → reg_wdata <= rx_byte → WR_BUS.
- State WR_BUS: reg_req = 1, reg_we = 1. On reg_ack: addr <= addr + 1 → WR_WAIT.
- State RD_BUS: reg_req = 1, reg_we = 0. On reg_ack: tx_byte <= reg_rdata, addr <= addr + 1 → RD_WAIT.
- State RD_WAIT: rx_valid (dummy byte, previous tx_byte shifted out) → RD_BUS (prefetch next).
- Latency:
  - rx_valid → reg_req high on the next clk edge.
  - reg_ack → reg_req low on the same edge that captures data.
  - No combinational path from any input to reg_req or tx_byte.
- Address wrap: addr increments modulo 2^ADDR_W, so 0x7F + 1 = 0x00 at ADDR_W = 7.
- Overrun: rx_valid while in WR_BUS or RD_BUS sets err_overrun, and the byte is discarded. The bus transaction continues.
- frame_end in CMD, WR_WAIT or RD_WAIT → IDLE next edge; tx_byte holds.
- frame_end in WR_BUS or RD_BUS: an internal end_pend flag is set and reg_req stays asserted until reg_ack. The write completes or read data is captured, then → IDLE.
- frame_start outside IDLE and the bus states: restart → CMD with tx_byte reload. In a bus state, start_pend is set; after reg_ack → CMD with reload.
- Simultaneous events:
  - rx_valid with frame_end: frame_end wins, byte discarded.
  - frame_end with frame_start: start wins (back-to-back frames).
- busy = (state != IDLE).

Optional Feature:
- Macro: SPI_REG_CTRL_TIMEOUT_EN.
- With the macro:
  - A watchdog counter runs while reg_req is high.
  - At TIMEOUT_CYC cycles without reg_ack, reg_req drops and the transaction is abandoned.
  - A read loads tx_byte <= 8'hEE; a write is dropped.
  - Next state is as if ack'd; addr still increments.
  - Extra output err_timeout (1 bit, sticky, cleared by frame_start, reset 0).
- Without the macro: no counter and no err_timeout port; reg_req waits indefinitely.

Decomposition:
- Package spi_reg_pkg:
  - state enum state_t {IDLE, CMD, WR_WAIT, WR_BUS, RD_BUS, RD_WAIT}.
  - Constants: CMD_RD_BIT = 7, TIMEOUT_FILL = 8'hEE, default STATUS_BYTE.
- Sub-module bus_watchdog: counter with start/clear/expire, instantiated only under SPI_REG_CTRL_TIMEOUT_EN.
- The rest stays flat: FSM plus datapath registers.

Test Plan:
- Write burst: frame_start, rx 0x05, 0x11, 0x22, ack after 2 cycles each, frame_end → bus writes addr 5 = 0x11 and addr 6 = 0x22; tx_byte = 0xA5 throughout; busy 0 after end.
- Read burst: rx 0x83, ack with rdata 0x3C then 0x4D → reads at 3 then 4; tx_byte = 0x3C after the first ack and 0x4D after the dummy byte plus second ack.
- Wrap: write command 0x7F with 2 data bytes → addresses 0x7F then 0x00.
- Overrun: write byte, hold ack 20 cycles, inject rx_valid → err_overrun = 1, only one write issued; next frame_start clears err_overrun.
- frame_end during WR_BUS: reg_req held until ack at cycle +5, write completes, then IDLE; no further req.
- Timeout (macro on, TIMEOUT_CYC = 8): read with no ack → reg_req drops after 8 cycles, tx_byte = 0xEE, err_timeout = 1; async rst_n low mid-read → all outputs reset immediately.
